// File: rtl/piece_generator.sv
`default_nettype none
// ============================================================================
// Module   : piece_generator
// Brief    : LFSR-driven Tetris piece source with reroll queue and one-piece
//            preview, handshaking new pieces to the game FSM.
// Revision : 1.0 - initial release
// ============================================================================
module piece_generator #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          QUEUE_DEPTH  = 3,
    parameter int          REROLL_LIMIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spawn_req,
    output logic        spawn_valid,
    output logic [1:0]  random_block,
    output logic [1:0]  next_block,
    output logic        queue_ready,
    output logic        req_dropped,
    output logic [15:0] pieces_dealt
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int RW = (REROLL_LIMIT > 0) ? $clog2(REROLL_LIMIT + 1) : 1;
    localparam logic [15:0]   c_seed      = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CW-1:0] c_last_slot = CW'(QUEUE_DEPTH - 1);
    localparam logic [RW-1:0] c_limit     = RW'(REROLL_LIMIT);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_READY  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_lfsr;
    logic [1:0]      r_queue [QUEUE_DEPTH];
    logic [CW-1:0]   r_count;
    logic [1:0]      r_last;
    logic            r_has_last;
    logic [RW-1:0]   r_reroll;
    logic            r_pending;
    logic            r_spawn_valid;
    logic [1:0]      r_random_block;
    logic            r_queue_ready;
    logic            r_req_dropped;
    logic [15:0]     r_pieces_dealt;

    logic [1:0]      w_cand;
    logic            w_repeat;
    logic            w_accept;
    logic            w_discard;
    logic            w_deal;
    logic            w_drop;
    logic            w_fb;

    assign w_cand   = r_lfsr[1:0];
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_drop   = spawn_req & r_pending;
    // A repeat only counts against a real previous code; an empty queue has none.
    assign w_repeat = r_has_last && (w_cand == r_last) && (r_reroll < c_limit);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_discard    = 1'b0;
        w_deal       = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_repeat) begin
                    w_discard = 1'b1;
                end else begin
                    w_accept = 1'b1;
                    if (r_count == c_last_slot) begin
                        w_next_state = S_READY;
                    end
                end
            end
            S_REFILL: begin
                if (w_repeat) begin
                    w_discard = 1'b1;
                end else begin
                    w_accept     = 1'b1;
                    w_next_state = S_READY;
                end
            end
            S_READY: begin
                if (spawn_req || r_pending) begin
                    w_deal       = 1'b1;
                    w_next_state = S_REFILL;
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr         <= c_seed;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_queue[i] <= 2'b00;
            end
            r_count        <= '0;
            r_last         <= 2'b00;
            r_has_last     <= 1'b0;
            r_reroll       <= '0;
            r_pending      <= 1'b0;
            r_spawn_valid  <= 1'b0;
            r_random_block <= 2'b00;
            r_queue_ready  <= 1'b0;
            r_req_dropped  <= 1'b0;
            r_pieces_dealt <= 16'h0000;
        end else begin
            r_lfsr        <= {r_lfsr[14:0], w_fb};
            r_spawn_valid <= w_deal;
            r_req_dropped <= w_drop;
            r_queue_ready <= (w_next_state == S_READY);

            if (w_deal) begin
                r_pending <= 1'b0;
            end else if (spawn_req) begin
                r_pending <= 1'b1;
            end

            if (w_accept) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (r_count == CW'(i)) begin
                        r_queue[i] <= w_cand;
                    end
                end
                r_count    <= r_count + 1'b1;
                r_last     <= w_cand;
                r_has_last <= 1'b1;
                r_reroll   <= '0;
            end else if (w_discard) begin
                r_reroll <= r_reroll + 1'b1;
            end

            if (w_deal) begin
                r_random_block <= r_queue[0];
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                    r_queue[i] <= r_queue[i+1];
                end
                r_queue[QUEUE_DEPTH-1] <= 2'b00;
                r_count        <= r_count - 1'b1;
                r_pieces_dealt <= r_pieces_dealt + 16'h0001;
            end
        end
    end

    assign spawn_valid  = r_spawn_valid;
    assign random_block = r_random_block;
    assign next_block   = r_queue[0];
    assign queue_ready  = r_queue_ready;
    assign req_dropped  = r_req_dropped;
    assign pieces_dealt = r_pieces_dealt;

endmodule
`default_nettype wire

// File: tb/tb_piece_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_generator
// Brief    : Self-checking bench for piece_generator against a queue-based
//            reference model, with directed and random request traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piece_generator;

    localparam logic [15:0] SEED         = 16'h0001;
    localparam int          QUEUE_DEPTH  = 3;
    localparam int          REROLL_LIMIT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spawn_req = 1'b0;
    logic        spawn_valid;
    logic [1:0]  random_block;
    logic [1:0]  next_block;
    logic        queue_ready;
    logic        req_dropped;
    logic [15:0] pieces_dealt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_lfsr;
    int m_q[$];
    int m_last;
    bit m_has_last;
    int m_rr;
    bit m_pend;
    bit m_ready;
    bit m_valid;
    int m_block;
    bit m_drop;
    int m_cnt;

    piece_generator #(
        .SEED         (SEED),
        .QUEUE_DEPTH  (QUEUE_DEPTH),
        .REROLL_LIMIT (REROLL_LIMIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .spawn_req    (spawn_req),
        .spawn_valid  (spawn_valid),
        .random_block (random_block),
        .next_block   (next_block),
        .queue_ready  (queue_ready),
        .req_dropped  (req_dropped),
        .pieces_dealt (pieces_dealt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit req);
        int cand;
        int fb;
        if (rst) begin
            m_lfsr = int'(SEED); m_q.delete(); m_last = 0; m_has_last = 0; m_rr = 0;
            m_pend = 0; m_ready = 0; m_valid = 0; m_block = 0; m_drop = 0; m_cnt = 0;
            return;
        end
        cand    = m_lfsr % 4;
        m_valid = 0;
        m_drop  = req && m_pend;
        if (m_ready) begin
            if (req || m_pend) begin
                m_block = m_q.pop_front();
                m_valid = 1;
                m_cnt   = (m_cnt + 1) % 65536;
                m_pend  = 0;
                m_ready = 0;
            end
        end else begin
            if (req) m_pend = 1;
            if (m_has_last && cand == m_last && m_rr < REROLL_LIMIT) begin
                m_rr++;
            end else begin
                m_q.push_back(cand);
                m_last = cand; m_has_last = 1; m_rr = 0;
                if (m_q.size() == QUEUE_DEPTH) m_ready = 1;
            end
        end
        fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr * 2) % 65536) + fb;
    endtask

    task automatic cycle(input bit rst, input bit req);
        reset     = rst;
        spawn_req = req;
        @(posedge clock);
        model_edge(rst, req);
        #1;
        chk("spawn_valid",  16'(spawn_valid),  16'(m_valid));
        chk("random_block", 16'(random_block), 16'(m_block));
        chk("next_block",   16'(next_block),   (m_q.size() > 0) ? 16'(m_q[0]) : 16'h0);
        chk("queue_ready",  16'(queue_ready),  16'(m_ready));
        chk("req_dropped",  16'(req_dropped),  16'(m_drop));
        chk("pieces_dealt", pieces_dealt,      16'(m_cnt));
    endtask

    int prev_valid;

    initial begin
        // Reset state
        cycle(1, 0);
        cycle(1, 1);
        chk("rst_outputs", {11'd0, spawn_valid, random_block, queue_ready, req_dropped}, 16'h0);
        chk("rst_lfsr", dut.r_lfsr, 16'h0001);

        // Initial fill: 01,10,00
        cycle(0, 0);
        chk("fill1_nb", 16'(next_block), 16'h1);
        cycle(0, 0);
        cycle(0, 0);
        chk("fill_ready", 16'(queue_ready), 16'h1);
        chk("fill_nb",    16'(next_block),  16'h1);

        // First deal, then two requests during refill
        cycle(0, 1);
        chk("deal1_valid", 16'(spawn_valid),  16'h1);
        chk("deal1_block", 16'(random_block), 16'h1);
        chk("deal1_nb",    16'(next_block),   16'h2);
        chk("deal1_cnt",   pieces_dealt,      16'h1);
        cycle(0, 1);
        chk("reroll_busy", 16'(queue_ready), 16'h0);
        cycle(0, 1);
        chk("drop_pulse",  16'(req_dropped), 16'h1);
        chk("refill_rdy",  16'(queue_ready), 16'h1);
        cycle(0, 0);
        chk("pend_valid", 16'(spawn_valid),  16'h1);
        chk("pend_block", 16'(random_block), 16'h2);
        chk("pend_cnt",   pieces_dealt,      16'h2);
        cycle(0, 0);
        chk("single_deal", 16'(spawn_valid), 16'h0);

        // Reset mid-refill (one deal then reset while refilling)
        while (!queue_ready) cycle(0, 0);
        cycle(0, 1);
        cycle(1, 0);
        chk("midrst_lfsr", dut.r_lfsr, 16'h0001);
        chk("midrst_outs", {11'd0, spawn_valid, random_block, queue_ready, req_dropped}, 16'h0);
        chk("midrst_cnt",  pieces_dealt, 16'h0);
        cycle(0, 0);
        chk("refill1_nb", 16'(next_block), 16'h1);
        cycle(0, 0);
        cycle(0, 0);
        chk("refill_rdy2", 16'(queue_ready), 16'h1);
        chk("refill_nb2",  16'(next_block),  16'h1);

        // Random traffic against the model
        prev_valid = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) == 0));
            if (prev_valid != 0) chk("valid_gap", 16'(spawn_valid), 16'h0);
            prev_valid = int'(spawn_valid);
        end

        // Counter wrap
        cycle(0, 0);
        while (!queue_ready) cycle(0, 0);
        force dut.r_pieces_dealt = 16'hFFFF;
        #1;
        release dut.r_pieces_dealt;
        m_cnt = 16'hFFFF;
        chk("wrap_pre", pieces_dealt, 16'hFFFF);
        cycle(0, 1);
        chk("wrap_cnt",   pieces_dealt, 16'h0000);
        chk("wrap_valid", 16'(spawn_valid), 16'h1);
        cycle(0, 0);
        chk("wrap_pulse", 16'(spawn_valid), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
